regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port register file for the datapath: NUM_RD registered
//   read ports, two write ports with defined collision priority, optional
//   hardwired-zero entry 0 and optional write-to-read bypass. Reset clears the
//   array with a one-entry-per-cycle sweep FSM and flags it on busy.
// PARAMETERS
//   DATA_W   32  width of each register entry
//   ADDR_W   5   address width; DEPTH = 2**ADDR_W entries
//   NUM_RD   2   number of read ports (>=1)
//   ZERO_REG 1   1: entry 0 reads as 0, writes to it discarded
//   BYPASS   1   1: same-cycle write data forwarded to matching read port
// PORTS
//   clk      in   1               clock, all state on posedge
//   rst      in   1               synchronous, active-high reset
//   rd_en    in   NUM_RD          per-port read enable
//   rd_addr  in   NUM_RD*ADDR_W   packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data  out  NUM_RD*DATA_W   packed registered read data, port k at [k*DATA_W +: DATA_W]
//   wr0_en   in   1               write port 0 enable
//   wr0_addr in   ADDR_W          write port 0 address
//   wr0_data in   DATA_W          write port 0 data
//   wr1_en   in   1               write port 1 enable (higher priority)
//   wr1_addr in   ADDR_W          write port 1 address
//   wr1_data in   DATA_W          write port 1 data
//   busy     out  1               high while clear sweep in progress
// BEHAVIOUR
// - Reset values: rd_data all 0, busy 1, FSM CLEAR, clear pointer 0.
// - FSM: CLEAR, RUN. rst high at an edge -> CLEAR, ptr<=0, rd_data<=0 (any state).
//   CLEAR, rst low: store[ptr]<=0, ptr<=ptr+1; on edge clearing DEPTH-1 -> RUN.
//   busy = (state==CLEAR); high exactly DEPTH edges after rst deasserts.
// - Reset mid-sweep restarts from ptr 0; full DEPTH cycles again after release.
// - While busy: wr0/wr1 dropped, rd_en ignored, rd_data held at 0.
// - RUN writes: wrN_en=1 -> store[wrN_addr]<=wrN_data at edge. Both enabled,
//   same addr -> wr1 data stored. Different addrs -> both stored.
// - ZERO_REG=1: writes to addr 0 discarded; reads of addr 0 return 0, incl. bypass.
// - Reads: latency 1. rd_en[k]=1 at edge -> rd_data[k] <= value of rd_addr[k];
//   rd_en[k]=0 -> rd_data[k] holds. Ports independent; any ports may share an addr.
// - BYPASS=1: enabled write to rd_addr[k] in same cycle -> rd_data[k] gets the
//   write data (wr1 if both match). BYPASS=0 -> pre-write contents returned.
// - Read of an address written in the previous cycle always returns new data.
// - No X on outputs after reset; all address values legal (no out-of-range).
// TESTING
// 1 Fill all entries 0xA5A5A5A5, pulse rst 1 cycle -> busy=1 for exactly 32
//   cycles, rd_data=0 throughout; then read addr 0..31 -> all 0x00000000.
// 2 wr0 addr 5 =0xDEADBEEF; next cycle rd_en0=1 addr 5 -> rd_data0=0xDEADBEEF
//   one edge later; rd_en0=0 afterwards -> value held while addr changes.
// 3 Same cycle wr0 addr 7 =0x12345678, rd_en0=1 addr 7 (old 0) -> BYPASS=1:
//   rd_data0=0x12345678; BYPASS=0: rd_data0=0, then 0x12345678 on re-read.
// 4 wr0 addr 9 =0x1, wr1 addr 9 =0x2 same cycle, port1 reading 9 -> rd_data1=0x2
//   (bypass), later re-read 0x2; wr0 addr 3 =0x3 / wr1 addr 4 =0x4 -> both stored.
// 5 wr1 addr 0 =0xFFFFFFFF, both ports read 0 same and next cycle -> 0 on all;
//   ZERO_REG=0 build -> 0xFFFFFFFF (bypass and stored).
// 6 Reassert rst at busy cycle 10, writes attempted during sweep -> busy high 32
//   cycles from new release; writes lost, all entries read 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write ports and registered reads.
// After reset, the array is cleared one entry per cycle and busy stays high until the sweep finishes.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  output logic                     busy
);

  // state  | meaning
  // CLEAR  | sweeping zeros into the array, ports ignored
  // RUN    | normal read/write operation
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] store [DEPTH];
  logic              run;
  logic              wr0_ok;
  logic              wr1_ok;

  assign run    = (state == ST_RUN);
  assign busy   = (state == ST_CLEAR);
  assign wr0_ok = run && !rst && wr0_en && !(ZERO_REG != 0 && wr0_addr == '0);
  assign wr1_ok = run && !rst && wr1_en && !(ZERO_REG != 0 && wr1_addr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else if (state == ST_CLEAR) begin
      ptr <= ptr + 1'b1;
      if (ptr == {ADDR_W{1'b1}})
        state <= ST_RUN;
    end
  end

  // wr1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_CLEAR) begin
      store[ptr] <= '0;
    end else begin
      if (wr0_ok)
        store[wr0_addr] <= wr0_data;
      if (wr1_ok)
        store[wr1_addr] <= wr1_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = store[addr];
    if (BYPASS != 0 && wr0_ok && wr0_addr == addr)
      val = wr0_data;
    if (BYPASS != 0 && wr1_ok && wr1_addr == addr)
      val = wr1_data;
    if (ZERO_REG != 0 && addr == '0)
      val = '0;
    return val;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (run) begin
      for (int k = 0; k < NUM_RD; k++) begin
        if (rd_en[k])
          rd_data[k*DATA_W +: DATA_W] <= read_val(rd_addr[k*ADDR_W +: ADDR_W]);
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_regfile_mp;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_RD   = 2;
  localparam int ZERO_REG = 1;
  localparam int BYPASS   = 1;
  localparam int DEPTH    = 2 ** ADDR_W;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr0_en, wr1_en;
  logic [ADDR_W-1:0]        wr0_addr, wr1_addr;
  logic [DATA_W-1:0]        wr0_data, wr1_data;
  logic                     busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  regfile_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: contents become all-zero once a reset is seen; the only
  // observable effect of the sweep is DEPTH cycles of busy with ports ignored.
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DATA_W-1:0] m_rd  [NUM_RD];
  int                m_left = 0;

  function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] a);
    if (ZERO_REG != 0 && a == 0) return '0;
    if (BYPASS != 0 && wr1_en && wr1_addr == a) return wr1_data;
    if (BYPASS != 0 && wr0_en && wr0_addr == a) return wr0_data;
    return m_mem[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      for (int k = 0; k < NUM_RD; k++) m_rd[k] = '0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
    end else begin
      for (int k = 0; k < NUM_RD; k++)
        if (rd_en[k]) m_rd[k] = m_read(rd_addr[k*ADDR_W +: ADDR_W]);
      if (wr0_en && !(ZERO_REG != 0 && wr0_addr == 0)) m_mem[wr0_addr] = wr0_data;
      if (wr1_en && !(ZERO_REG != 0 && wr1_addr == 0)) m_mem[wr1_addr] = wr1_data;
    end
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", {31'b0, busy}, {31'b0, m_left > 0});
      for (int k = 0; k < NUM_RD; k++)
        check("model_rd_data", rd_data[k*DATA_W +: DATA_W], m_rd[k]);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    rd_en = '0; wr0_en = 0; wr1_en = 0;
  endtask

  // Counts busy cycles seen at negedges after a release; optionally drives random writes.
  task automatic count_busy(input bit do_writes, output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      check("busy_rd0_zero", rd_data[0 +: DATA_W], '0);
      wr0_en = do_writes; wr0_addr = ADDR_W'($urandom); wr0_data = $urandom;
      wr1_en = do_writes; wr1_addr = ADDR_W'($urandom); wr1_data = $urandom;
      rd_en = do_writes ? '1 : '0; rd_addr = NUM_RD*ADDR_W'($urandom);
      step();
    end
    idle();
  endtask

  task automatic read1(input int port, input logic [ADDR_W-1:0] a);
    rd_en = '0; rd_en[port] = 1'b1;
    rd_addr[port*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic pulse_rst();
    rst = 1; step(); rst = 0;
  endtask

  int cnt;

  initial begin
    rst = 1; idle(); rd_addr = '0;
    wr0_addr = '0; wr1_addr = '0; wr0_data = '0; wr1_data = '0;
    step();
    chk_en = 1'b1;
    check("reset_busy", {31'b0, busy}, 32'd1);
    check("reset_rd_data", rd_data[DATA_W +: DATA_W], '0);
    rst = 0;
    count_busy(0, cnt);

    // Fill with pattern, then reset and confirm the sweep.
    for (int a = 0; a < DEPTH; a++) begin
      wr0_en = 1; wr0_addr = ADDR_W'(a); wr0_data = 32'hA5A5A5A5; step();
    end
    idle();
    pulse_rst();
    count_busy(0, cnt);
    check("sweep_length", cnt, 32'd32);
    for (int a = 0; a < DEPTH; a++) begin
      read1(0, ADDR_W'(a)); step();
      check("cleared_entry", rd_data[0 +: DATA_W], '0);
    end
    idle();

    // Write then read; hold while address changes.
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF; step(); idle();
    read1(0, 5); step();
    check("rd_after_wr", rd_data[0 +: DATA_W], 32'hDEADBEEF);
    rd_en = '0; rd_addr[0 +: ADDR_W] = 6; step();
    check("rd_hold", rd_data[0 +: DATA_W], 32'hDEADBEEF);

    // Same-cycle bypass.
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h12345678; read1(0, 7); step(); idle();
    check("bypass_wr0", rd_data[0 +: DATA_W], 32'h12345678);

    // Write collision: wr1 wins, also through bypass.
    wr0_en = 1; wr0_addr = 9; wr0_data = 32'h1;
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'h2; read1(1, 9); step(); idle();
    check("collide_bypass", rd_data[DATA_W +: DATA_W], 32'h2);
    read1(1, 9); step();
    check("collide_stored", rd_data[DATA_W +: DATA_W], 32'h2);
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'h3;
    wr1_en = 1; wr1_addr = 4; wr1_data = 32'h4; rd_en = '0; step(); idle();
    rd_en = 2'b11; rd_addr = {5'd4, 5'd3}; step(); idle();
    check("dual_wr_p0", rd_data[0 +: DATA_W], 32'h3);
    check("dual_wr_p1", rd_data[DATA_W +: DATA_W], 32'h4);

    // Hardwired zero entry.
    wr1_en = 1; wr1_addr = 0; wr1_data = 32'hFFFFFFFF; rd_en = 2'b11; rd_addr = '0; step();
    wr1_en = 0;
    check("zero_bypass", rd_data, '0);
    step(); idle();
    check("zero_stored", rd_data, '0);

    // Reset mid-sweep with writes attempted throughout.
    pulse_rst();
    for (int i = 0; i < 10; i++) begin
      wr0_en = 1; wr0_addr = ADDR_W'($urandom); wr0_data = $urandom; step();
    end
    idle();
    pulse_rst();
    count_busy(1, cnt);
    check("restart_sweep_length", cnt, 32'd32);
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 2'b11; rd_addr = {ADDR_W'(DEPTH - 1 - a), ADDR_W'(a)}; step();
      check("restart_cleared", rd_data, '0);
    end
    idle();

    // Random traffic against the model; narrow address range forces collisions.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 399) == 0);
      rd_en    = NUM_RD'($urandom);
      for (int k = 0; k < NUM_RD; k++)
        rd_addr[k*ADDR_W +: ADDR_W] = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
      wr0_en   = $urandom_range(0, 1) == 1;
      wr0_addr = ADDR_W'($urandom_range(0, 7));
      wr0_data = $urandom;
      wr1_en   = $urandom_range(0, 2) == 0;
      wr1_addr = ADDR_W'($urandom_range(0, 7));
      wr1_data = $urandom;
      step();
    end
    rst = 0; idle(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
